// File: rtl/pipe_pkg.sv
// Shared types for the forwarding/hazard unit: entry structs,
// select encoding and select-width derivation.
package pipe_pkg;

    // Widest register address the entry structs can carry.
    // Narrower REG_AW values are zero-extended into it.
    localparam int MAX_AW = 8;

    // Select value meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    typedef logic [MAX_AW-1:0] reg_t;

    // Write-side view of an entry: what the forward comparator needs
    typedef struct packed {
        logic valid;
        logic regwrite;
        reg_t rd;
    } src_t;

    typedef struct packed {
        logic load;
        src_t w;
    } post_t;

    typedef struct packed {
        logic load;
        reg_t rs;
        reg_t rt;
        src_t w;
    } ex_t;

    function automatic int sel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

    function automatic logic is_producer(input src_t w, input reg_t r);
        return w.valid & w.regwrite & (w.rd != '0) & (w.rd == r);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority comparator: picks the youngest post-EX producer of src.
// Ports: src (register read in EX), w (entries 1..N), sel (0 = RF).
module fwd_select
    import pipe_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = sel_width(NUM_FWD)
) (
    input  reg_t                   src,
    input  src_t [NUM_FWD-1:0]     w,
    output logic [SEL_W-1:0]       sel
);

    // Scan oldest to youngest so the lowest index is left in sel
    always_comb begin
        sel = SEL_W'(FWD_RF);
        for (int k = NUM_FWD; k >= 1; k--) begin
            if (is_producer(w[k-1], src)) begin
                sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destinations; drives EX bypass selects, load-use
// stall and a saturating stall counter.
// Ports: clk, rst_n, ID fields (id_*), flush, freeze -> stall,
//        fwd_a, fwd_b, stall_cnt (cleared by stall_cnt_clr).
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_FWD    = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = sel_width(NUM_FWD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    ex_t                  ex_q;
    post_t [NUM_FWD-1:0]  p_q;
    src_t  [NUM_FWD-1:0]  p_w;

    reg_t rs_w;
    reg_t rt_w;
    logic haz_rs;
    logic haz_rt;

    assign rs_w = reg_t'(id_rs);
    assign rt_w = reg_t'(id_rt);

    always_comb begin
        for (int k = 0; k < NUM_FWD; k++) begin
            p_w[k] = p_q[k].w;
        end
    end

    fwd_select #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_sel_a (
        .src (ex_q.rs),
        .w   (p_w),
        .sel (fwd_a)
    );

    fwd_select #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_sel_b (
        .src (ex_q.rt),
        .w   (p_w),
        .sel (fwd_b)
    );

    // A load at post-EX index k reaches the forwardable stage after
    // LOAD_STAGE-k more edges; a consumer entering EX next edge still
    // has to wait while k+1 < LOAD_STAGE (EX counts as k = 0).
    always_comb begin
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        if (LOAD_STAGE > 1 && ex_q.load) begin
            haz_rs = is_producer(ex_q.w, rs_w);
            haz_rt = is_producer(ex_q.w, rt_w);
        end
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (k + 1 < LOAD_STAGE && p_q[k-1].load) begin
                haz_rs = haz_rs | is_producer(p_q[k-1].w, rs_w);
                haz_rt = haz_rt | is_producer(p_q[k-1].w, rt_w);
            end
        end
    end

    assign stall = id_valid & ~flush & ~freeze & (haz_rs | haz_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
            p_q  <= '0;
        end else if (!freeze) begin
            for (int k = NUM_FWD - 1; k >= 1; k--) begin
                p_q[k] <= p_q[k-1];
            end
            p_q[0].load <= ex_q.load;
            p_q[0].w    <= ex_q.w;
            if (stall || flush || !id_valid) begin
                ex_q <= '0;
            end else begin
                ex_q.load       <= id_memread;
                ex_q.rs         <= rs_w;
                ex_q.rt         <= rt_w;
                ex_q.w.valid    <= 1'b1;
                ex_q.w.regwrite <= id_regwrite;
                ex_q.w.rd       <= reg_t'(id_rd);
            end
        end
    end

    // stall is already 0 while frozen, so the count holds then too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
